// File: rtl/touch_emu_pkg.sv
// Shared types and constants for the touch-panel ADC emulator.
package touch_emu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_BUSY,
      ST_DATA
   } state_e;

   localparam logic [1:0] ADDR_PEN = 2'd0;
   localparam logic [1:0] ADDR_X   = 2'd1;
   localparam logic [1:0] ADDR_Y   = 2'd2;
   localparam logic [1:0] ADDR_CNT = 2'd3;

   localparam logic [2:0] CH_X = 3'b101;
   localparam logic [2:0] CH_Y = 3'b001;

   localparam int CODE_W = 12;

   function automatic logic [CODE_W-1:0] sel_code(input logic [2:0]        ch,
                                                  input logic [CODE_W-1:0] x,
                                                  input logic [CODE_W-1:0] y);
      logic [CODE_W-1:0] code;
      code = '0;
      if (ch == CH_X) code = x;
      else if (ch == CH_Y) code = y;
      return code;
   endfunction

endpackage

// File: rtl/touch_emu_sync.sv
// N-stage synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses taken from the synchronized level.
module touch_emu_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;

endmodule

// File: rtl/touch_panel_adc_emu.sv
// ADS7843-style touch ADC emulator: Avalon-MM register file plus SPI slave FSM.
// Optional build macro: TOUCH_EMU_CONV_COUNT_EN (conversion counter at addr 3).
//
// state | meaning
// IDLE  | cs_n high, outputs parked at 0
// CMD   | hunting for start bit, then shifting in the 7 control bits
// BUSY  | first fall raises busy, second fall drives the MSB
// DATA  | shifting the snapshotted code out on each fall
module touch_panel_adc_emu
   import touch_emu_pkg::*;
#(
   parameter int DCLK_SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        spi_dclk,
   input  logic        spi_cs_n,
   input  logic        spi_din,
   output logic        spi_dout,
   output logic        spi_busy,
   output logic        pen_irq_n
);

   logic dclk_rise, dclk_fall, dclk_lvl_unused;
   logic cs_q, cs_fall, cs_rise_unused;
   logic din_q, din_rise_unused, din_fall_unused;

   touch_emu_sync #(.STAGES(DCLK_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dclk (
      .clk(clk), .reset_n(reset_n), .d(spi_dclk),
      .q(dclk_lvl_unused), .rise(dclk_rise), .fall(dclk_fall));

   touch_emu_sync #(.STAGES(DCLK_SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .reset_n(reset_n), .d(spi_cs_n),
      .q(cs_q), .rise(cs_rise_unused), .fall(cs_fall));

   touch_emu_sync #(.STAGES(DCLK_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
      .clk(clk), .reset_n(reset_n), .d(spi_din),
      .q(din_q), .rise(din_rise_unused), .fall(din_fall_unused));

   logic              wr;
   logic              pen_down_q;
   logic [CODE_W-1:0] x_code_q, y_code_q;
   logic [31:0]       rd_d;
   logic              conv_done;
   logic              wdata_unused;

   assign wr           = chipselect & ~write_n;
   assign wdata_unused = ^writedata[31:CODE_W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pen_down_q <= 1'b0;
         x_code_q   <= '0;
         y_code_q   <= '0;
      end else if (wr) begin
         case (address)
            ADDR_PEN: pen_down_q <= writedata[0];
            ADDR_X:   x_code_q   <= writedata[CODE_W-1:0];
            ADDR_Y:   y_code_q   <= writedata[CODE_W-1:0];
            default:  ;
         endcase
      end
   end

`ifdef TOUCH_EMU_CONV_COUNT_EN
   logic [15:0] conv_count_q, conv_count_d;

   // Host clear takes priority over a conversion finishing in the same cycle.
   always_comb begin
      conv_count_d = conv_count_q;
      if (wr && address == ADDR_CNT) conv_count_d = '0;
      else if (conv_done && conv_count_q != 16'hFFFF) conv_count_d = conv_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) conv_count_q <= '0;
      else          conv_count_q <= conv_count_d;
   end
`else
   logic conv_done_unused;
   assign conv_done_unused = conv_done;
`endif

   always_comb begin
      rd_d = '0;
      case (address)
         ADDR_PEN: rd_d[0]          = pen_down_q;
         ADDR_X:   rd_d[CODE_W-1:0] = x_code_q;
         ADDR_Y:   rd_d[CODE_W-1:0] = y_code_q;
         ADDR_CNT: begin
`ifdef TOUCH_EMU_CONV_COUNT_EN
            rd_d[15:0] = conv_count_q;
`endif
         end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_d;
   end

   state_e            state_q, state_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [5:0]        cmd_q, cmd_d;
   logic              mode_q, mode_d;
   logic [CODE_W-1:0] word_q, word_d;
   logic              busy_ph_q, busy_ph_d;
   logic              dout_q, dout_d;
   logic              busy_q, busy_d;
   logic              pd_irq_en_q, pd_irq_en_d;
   logic              pen_irq_n_q, pen_irq_n_d;
   logic [6:0]        ctrl;
   logic [3:0]        nbits;
   logic              conv_active;

   assign ctrl        = {cmd_q, din_q};
   assign nbits       = mode_q ? 4'd8 : 4'd12;
   assign conv_active = (state_q == ST_BUSY) || (state_q == ST_DATA);

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      cmd_d       = cmd_q;
      mode_d      = mode_q;
      word_d      = word_q;
      busy_ph_d   = busy_ph_q;
      dout_d      = dout_q;
      busy_d      = busy_q;
      pd_irq_en_d = pd_irq_en_q;
      conv_done   = 1'b0;

      if (cs_q) begin
         state_d   = ST_IDLE;
         dout_d    = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
         busy_ph_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_d   = ST_CMD;
                  bit_cnt_d = '0;
               end
            end
            ST_CMD: begin
               if (dclk_rise) begin
                  if (bit_cnt_q == 4'd0) begin
                     if (din_q) bit_cnt_d = 4'd1;
                  end else if (bit_cnt_q == 4'd7) begin
                     // ctrl = A2 A1 A0 MODE SER/DFR PD1 PD0
                     mode_d      = ctrl[3];
                     pd_irq_en_d = ~ctrl[0];
                     word_d      = sel_code(ctrl[6:4], x_code_q, y_code_q);
                     busy_ph_d   = 1'b0;
                     bit_cnt_d   = '0;
                     state_d     = ST_BUSY;
                  end else begin
                     cmd_d     = {cmd_q[4:0], din_q};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            ST_BUSY: begin
               if (dclk_fall) begin
                  if (!busy_ph_q) begin
                     busy_d    = 1'b1;
                     dout_d    = 1'b0;
                     busy_ph_d = 1'b1;
                  end else begin
                     busy_d    = 1'b0;
                     dout_d    = word_q[CODE_W-1];
                     word_d    = {word_q[CODE_W-2:0], 1'b0};
                     bit_cnt_d = 4'd1;
                     state_d   = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (dclk_fall) begin
                  if (bit_cnt_q == nbits) begin
                     dout_d    = 1'b0;
                     conv_done = 1'b1;
                     bit_cnt_d = '0;
                     state_d   = ST_CMD;
                  end else begin
                     dout_d    = word_q[CODE_W-1];
                     word_d    = {word_q[CODE_W-2:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Pen interrupt is masked while a conversion is in flight.
      pen_irq_n_d = !(pen_down_q && pd_irq_en_q && !conv_active);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         cmd_q       <= '0;
         mode_q      <= 1'b0;
         word_q      <= '0;
         busy_ph_q   <= 1'b0;
         dout_q      <= 1'b0;
         busy_q      <= 1'b0;
         pd_irq_en_q <= 1'b1;
         pen_irq_n_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         cmd_q       <= cmd_d;
         mode_q      <= mode_d;
         word_q      <= word_d;
         busy_ph_q   <= busy_ph_d;
         dout_q      <= dout_d;
         busy_q      <= busy_d;
         pd_irq_en_q <= pd_irq_en_d;
         pen_irq_n_q <= pen_irq_n_d;
      end
   end

   assign spi_dout  = dout_q;
   assign spi_busy  = busy_q;
   assign pen_irq_n = pen_irq_n_q;

endmodule

// File: tb/tb_touch_panel_adc_emu.sv
// Directed bench for touch_panel_adc_emu: register table plus SPI frame sequences.
module tb_touch_panel_adc_emu;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        spi_dclk;
   logic        spi_cs_n;
   logic        spi_din;
   logic        spi_dout;
   logic        spi_busy;
   logic        pen_irq_n;

   int n_cmp = 0;
   int n_err = 0;

   touch_panel_adc_emu #(.DCLK_SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .spi_dclk(spi_dclk), .spi_cs_n(spi_cs_n), .spi_din(spi_din),
      .spi_dout(spi_dout), .spi_busy(spi_busy), .pen_irq_n(pen_irq_n));

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, summary not printed");
      $fatal(1, "watchdog");
   end

   function automatic int exp_cnt(input int n);
`ifdef TOUCH_EMU_CONV_COUNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      @(negedge clk);
      d = readdata;
      chipselect = 1'b0;
   endtask

   // One DCLK period: 8 clk low, sample at the rising edge, 8 clk high, then fall.
   task automatic clk_bit(input logic d, output logic dout_s, output logic busy_s);
      @(negedge clk);
      spi_din = d;
      repeat (7) @(negedge clk);
      dout_s = spi_dout;
      busy_s = spi_busy;
      spi_dclk = 1'b1;
      repeat (8) @(negedge clk);
      spi_dclk = 1'b0;
   endtask

   task automatic frame(input logic [7:0] cmd, input int nbits, input bit no_end,
                        input bit clr_end, output logic [11:0] word,
                        output logic busy_seen, output logic busy_extra,
                        output logic pen_mid);
      logic d, b;
      spi_cs_n = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) clk_bit(cmd[7-i], d, b);
      clk_bit(1'b0, d, b);
      busy_seen  = b;
      busy_extra = 1'b0;
      word       = '0;
      pen_mid    = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         clk_bit(1'b0, d, b);
         word = {word[10:0], d};
         if (b) busy_extra = 1'b1;
         if (i == 2) pen_mid = pen_irq_n;
      end
      if (!no_end) begin
         if (clr_end) begin
            repeat (2) @(negedge clk);
            address = 2'd3; writedata = 32'h0; chipselect = 1'b1; write_n = 1'b0;
            @(negedge clk);
            chipselect = 1'b0; write_n = 1'b1;
            repeat (6) @(negedge clk);
         end else begin
            repeat (8) @(negedge clk);
         end
         spi_cs_n = 1'b1;
         repeat (8) @(negedge clk);
      end
   endtask

   typedef struct {
      logic [1:0]  addr;
      bit          wr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [31:0] rd;
      logic [11:0] w;
      logic        bs, bx, pm;

      vecs[0] = '{2'd0, 1'b0, 32'h0,         32'h0,   1'b1};
      vecs[1] = '{2'd1, 1'b0, 32'h0,         32'h0,   1'b1};
      vecs[2] = '{2'd2, 1'b0, 32'h0,         32'h0,   1'b1};
      vecs[3] = '{2'd3, 1'b0, 32'h0,         32'h0,   1'b1};
      vecs[4] = '{2'd1, 1'b1, 32'hFFFF_FA5C, 32'hA5C, 1'b1};
      vecs[5] = '{2'd2, 1'b1, 32'h0000_05A1, 32'h5A1, 1'b1};
      vecs[6] = '{2'd0, 1'b1, 32'hFFFF_FFFF, 32'h1,   1'b0};
      vecs[7] = '{2'd3, 1'b1, 32'h0000_1234, 32'h0,   1'b0};
      vecs[8] = '{2'd0, 1'b1, 32'h0000_0002, 32'h0,   1'b1};
      vecs[9] = '{2'd1, 1'b0, 32'h0,         32'hA5C, 1'b1};

      reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'h0; spi_dclk = 1'b0; spi_cs_n = 1'b1; spi_din = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("reset_readdata", readdata, 32'h0);
      check("reset_dout", {31'b0, spi_dout}, 32'h0);
      check("reset_busy", {31'b0, spi_busy}, 32'h0);
      check("reset_pen_irq_n", {31'b0, pen_irq_n}, 32'h1);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].wr) reg_wr(vecs[i].addr, vecs[i].wdata);
         reg_rd(vecs[i].addr, rd);
         check($sformatf("reg_vec%0d_rd", i), rd, vecs[i].exp_rd);
         check($sformatf("reg_vec%0d_irq", i), {31'b0, pen_irq_n}, {31'b0, vecs[i].exp_irq});
      end

      reg_wr(2'd0, 32'h1);
      check("pen_irq_not_yet", {31'b0, pen_irq_n}, 32'h1);
      @(negedge clk);
      check("pen_irq_one_cycle", {31'b0, pen_irq_n}, 32'h0);
      reg_wr(2'd0, 32'h0);
      @(negedge clk);
      check("pen_irq_release", {31'b0, pen_irq_n}, 32'h1);

      frame(8'h90, 12, 1'b0, 1'b0, w, bs, bx, pm);
      check("y_frame_word", {20'b0, w}, 32'h5A1);
      check("y_frame_busy", {31'b0, bs}, 32'h1);
      check("y_frame_busy_clear", {31'b0, bx}, 32'h0);
      frame(8'hD0, 12, 1'b0, 1'b0, w, bs, bx, pm);
      check("x_frame_word", {20'b0, w}, 32'hA5C);
      check("x_frame_busy", {31'b0, bs}, 32'h1);
      check("x_frame_busy_clear", {31'b0, bx}, 32'h0);
      check("dout_idle_after_frame", {31'b0, spi_dout}, 32'h0);
      reg_rd(2'd3, rd);
      check("conv_count_2", rd, exp_cnt(2));

      reg_wr(2'd2, 32'h3F7);
      frame(8'h98, 8, 1'b0, 1'b0, w, bs, bx, pm);
      check("mode8_word", {20'b0, w}, 32'h03F);
      check("mode8_busy", {31'b0, bs}, 32'h1);
      reg_rd(2'd3, rd);
      check("conv_count_3", rd, exp_cnt(3));

      frame(8'hA0, 12, 1'b0, 1'b0, w, bs, bx, pm);
      check("unmapped_channel_word", {20'b0, w}, 32'h0);

      reg_wr(2'd0, 32'h1);
      repeat (2) @(negedge clk);
      check("pen_down_irq", {31'b0, pen_irq_n}, 32'h0);
      frame(8'hD1, 12, 1'b0, 1'b0, w, bs, bx, pm);
      check("pd0_frame_word", {20'b0, w}, 32'hA5C);
      check("pd0_frame_irq_masked_mid", {31'b0, pm}, 32'h1);
      check("pd0_irq_disabled_after", {31'b0, pen_irq_n}, 32'h1);
      frame(8'hD0, 12, 1'b0, 1'b0, w, bs, bx, pm);
      check("pd0clr_irq_masked_mid", {31'b0, pm}, 32'h1);
      check("pd0clr_irq_enabled_after", {31'b0, pen_irq_n}, 32'h0);
      reg_rd(2'd3, rd);
      check("conv_count_6", rd, exp_cnt(6));

      frame(8'hD0, 5, 1'b1, 1'b0, w, bs, bx, pm);
      check("abort_partial_word", {20'b0, w}, 32'h014);
      repeat (4) @(negedge clk);
      check("abort_dout_mid_word", {31'b0, spi_dout}, 32'h1);
      spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_dout_zero", {31'b0, spi_dout}, 32'h0);
      check("abort_busy_zero", {31'b0, spi_busy}, 32'h0);
      reg_rd(2'd3, rd);
      check("abort_count_unchanged", rd, exp_cnt(6));

      frame(8'h90, 12, 1'b0, 1'b1, w, bs, bx, pm);
      reg_rd(2'd3, rd);
      check("clear_beats_increment", rd, 32'h0);
      frame(8'h90, 12, 1'b0, 1'b0, w, bs, bx, pm);
      check("post_clear_word", {20'b0, w}, 32'h3F7);
      reg_rd(2'd3, rd);
      check("count_after_clear", rd, exp_cnt(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
